// File: rtl/wb_pkg.sv
// Shared types for the MEM->WB stage: load type encoding and the registered writeback entry.
// Entry fields are sized for the widest configuration; narrower builds use the low bits.
package wb_pkg;

  localparam int WB_XLEN_MAX   = 64;
  localparam int WB_REG_AW_MAX = 8;

  typedef enum logic [2:0] {
    LT_NONE = 3'b000,
    LT_LB   = 3'b001,
    LT_LH   = 3'b010,
    LT_LW   = 3'b011,
    LT_LBU  = 3'b100,
    LT_LHU  = 3'b101,
    LT_LWU  = 3'b110,
    LT_LD   = 3'b111
  } load_type_e;

  localparam load_type_e LOAD_NONE = LT_NONE;

  typedef struct packed {
    logic                     wb_en;
    logic                     float_wb_en;
    logic [WB_REG_AW_MAX-1:0] rd_addr;
    logic [WB_XLEN_MAX-1:0]   data;
    logic                     misalign;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Combinational load-data formatter: byte-offset extraction, sign/zero extension, illegal-code
// and (with MEM_WB_MISALIGN_EN defined) misalignment detection.
module load_formatter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  load_type_e       load_type,
  input  logic [OFF_W-1:0] byte_off,
  input  logic [XLEN-1:0]  dm,
  input  logic [XLEN-1:0]  alu,
  output logic [XLEN-1:0]  data,
  output logic             illegal,
  output logic             misalign
);

  logic [XLEN-1:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = dm >> {byte_off, 3'b000};
    data    = '0;
    illegal = 1'b0;
    case (load_type)
      LT_NONE: data = alu;
      LT_LB:   data = XLEN'($signed(shifted[7:0]));
      LT_LH:   data = XLEN'($signed(shifted[15:0]));
      LT_LW:   data = XLEN'($signed(shifted[31:0]));
      LT_LBU:  data = XLEN'(shifted[7:0]);
      LT_LHU:  data = XLEN'(shifted[15:0]);
      LT_LWU: begin
        if (XLEN == 64) data = XLEN'(shifted[31:0]);
        else            illegal = 1'b1;
      end
      LT_LD: begin
        if (XLEN == 64) data = shifted;
        else            illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef MEM_WB_MISALIGN_EN
  always_comb begin
    misalign = 1'b0;
    case (load_type)
      LT_LH, LT_LHU: misalign = byte_off[0];
      LT_LW, LT_LWU: misalign = |byte_off[1:0];
      LT_LD:         misalign = |byte_off;
      default:       misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: formats load data and holds it in a main register plus a skid register
// behind a valid/ready handshake. Optional misalign detection under MEM_WB_MISALIGN_EN.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_float_wb_en,
  input  logic [2:0]        in_load_type,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_dm_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_float_wb_en,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_misalign
);

  logic [XLEN-1:0] fmt_data;
  logic            fmt_illegal;
  logic            fmt_misalign;

  wb_entry_t in_entry;
  wb_entry_t main_q;
  wb_entry_t skid_q;
  logic      main_valid;
  logic      skid_valid;
  logic      accept;
  logic      main_free;

  load_formatter #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_fmt (
    .load_type (load_type_e'(in_load_type)),
    .byte_off  (in_byte_off),
    .dm        (in_dm_out),
    .alu       (in_alu_out),
    .data      (fmt_data),
    .illegal   (fmt_illegal),
    .misalign  (fmt_misalign)
  );

  always_comb begin
    in_entry                    = '0;
    in_entry.wb_en              = in_wb_en && !fmt_illegal && !fmt_misalign;
    in_entry.float_wb_en        = in_float_wb_en && !fmt_illegal && !fmt_misalign;
    in_entry.rd_addr[REG_AW-1:0] = in_rd_addr;
    in_entry.data[XLEN-1:0]     = fmt_data;
    in_entry.misalign           = fmt_misalign;
  end

  // Ready depends only on skid occupancy, keeping out_ready off the in_ready path.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid || out_ready;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: payload registers are reset too because their values are visible on the outputs.
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid       = main_valid;
  assign out_wb_en       = main_q.wb_en;
  assign out_float_wb_en = main_q.float_wb_en;
  assign out_rd_addr     = main_q.rd_addr[REG_AW-1:0];
  assign out_wb_data     = main_q.data[XLEN-1:0];
`ifdef MEM_WB_MISALIGN_EN
  assign out_misalign    = main_q.misalign;
`else
  assign out_misalign    = 1'b0;
`endif

  // Bits above the configured widths are constant and intentionally left unconnected.
  logic unused_main;
  assign unused_main = ^main_q;

endmodule
